// File: rtl/baud_pkg.sv
// Shared constants, increment helper and state type for the fractional baud generator.
package baud_pkg;

   localparam longint unsigned CLK_HZ         = 200_000_000;
   localparam int unsigned     ACC_W_DEF      = 28;
   localparam int unsigned     OVERSAMPLE_DEF = 16;

   // Rounded phase increment for a given baud and oversampling ratio.
   function automatic longint unsigned baud_inc(input longint unsigned clk_hz,
                                                input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned     acc_w);
      return (baud * os * (64'd1 << acc_w) + clk_hz / 2) / clk_hz;
   endfunction

   localparam longint unsigned DEFAULT_INC =
      baud_inc(CLK_HZ, 64'd115200, 64'(OVERSAMPLE_DEF), ACC_W_DEF);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/baud_nco.sv
// Phase accumulator with registered carry; carry_nxt exposes the carry about to be registered.
module baud_nco #(
   parameter int unsigned ACC_W = 28
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [ACC_W-1:0] inc,
   input  logic             clear,
   input  logic             run,
   output logic             carry,
   output logic             carry_nxt
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W:0]   sum;
   logic             carry_d;

   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, inc};
      acc_d   = acc_q;
      carry_d = 1'b0;
      if (clear) begin
         acc_d = '0;
      end else if (run) begin
         acc_d   = sum[ACC_W-1:0];
         carry_d = sum[ACC_W];
      end
   end

   assign carry_nxt = carry_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         acc_q <= '0;
         carry <= 1'b0;
      end else begin
         acc_q <= acc_d;
         carry <= carry_d;
      end
   end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: oversample tick, bit tick, mid-bit restart and
// increment changes deferred to bit boundaries.
module baud_gen_frac #(
   parameter int unsigned ACC_W       = baud_pkg::ACC_W_DEF,
   parameter int unsigned OVERSAMPLE  = baud_pkg::OVERSAMPLE_DEF,
   parameter int unsigned DEFAULT_INC = 32'(baud_pkg::DEFAULT_INC)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             inc_wr,
   input  logic [ACC_W-1:0] inc_data,
   output logic             os_tick,
   output logic             bit_tick,
   output logic             inc_pending,
   output logic             running
);

   import baud_pkg::*;

   localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

   state_e           state_q, state_d;
   logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic [ACC_W-1:0] inc_active_q, inc_active_d;
   logic [ACC_W-1:0] inc_pend_q, inc_pend_d;
   logic             pending_q, pending_d;
   logic             bit_tick_q, bit_tick_d;
   logic             nco_run, nco_clear, carry_nxt, boundary;

   // Accumulate only on a plain RUN edge; restart and exit both zero the phase.
   assign nco_run   = (state_q == RUN) & en & ~restart;
   assign nco_clear = ~nco_run;

   baud_nco #(
      .ACC_W(ACC_W)
   ) u_nco (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .inc      (inc_active_q),
      .clear    (nco_clear),
      .run      (nco_run),
      .carry    (os_tick),
      .carry_nxt(carry_nxt)
   );

   always_comb begin
      state_d      = state_q;
      os_cnt_d     = os_cnt_q;
      bit_tick_d   = 1'b0;
      inc_active_d = inc_active_q;
      inc_pend_d   = inc_pend_q;
      pending_d    = pending_q;
      boundary     = 1'b0;

      unique case (state_q)
         IDLE: begin
            os_cnt_d = '0;
            if (en) begin
               state_d  = RUN;
               boundary = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d  = IDLE;
               os_cnt_d = '0;
            end else if (restart) begin
               os_cnt_d = OS_HALF;
               boundary = 1'b1;
            end else if (carry_nxt) begin
               os_cnt_d   = os_cnt_q + OS_W'(1);
               bit_tick_d = (os_cnt_q == OS_LAST);
               boundary   = bit_tick_d;
            end
         end
         default: state_d = IDLE;
      endcase

      // A write on the boundary edge itself takes precedence over the queued value.
      if (boundary) begin
         if (inc_wr) begin
            inc_active_d = inc_data;
            inc_pend_d   = inc_data;
         end else if (pending_q) begin
            inc_active_d = inc_pend_q;
         end
         pending_d = 1'b0;
      end else if (inc_wr) begin
         inc_pend_d = inc_data;
         if (state_q == RUN) begin
            pending_d = 1'b1;
         end else begin
            inc_active_d = inc_data;
            pending_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         os_cnt_q     <= '0;
         inc_active_q <= ACC_W'(DEFAULT_INC);
         inc_pend_q   <= ACC_W'(DEFAULT_INC);
         pending_q    <= 1'b0;
         bit_tick_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         os_cnt_q     <= os_cnt_d;
         inc_active_q <= inc_active_d;
         inc_pend_q   <= inc_pend_d;
         pending_q    <= pending_d;
         bit_tick_q   <= bit_tick_d;
      end
   end

   assign bit_tick    = bit_tick_q;
   assign inc_pending = pending_q;
   assign running     = (state_q == RUN);

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_baud_gen_frac;

   localparam int unsigned ACC_W = 28;
   localparam int unsigned OS    = 16;
   localparam longint      MOD   = 64'sd1 << ACC_W;
   localparam longint      DEF   = 2473901;

   logic             sys_clk   = 1'b0;
   logic             sys_rst_n = 1'b0;
   logic             en        = 1'b0;
   logic             restart   = 1'b0;
   logic             inc_wr    = 1'b0;
   logic [ACC_W-1:0] inc_data  = '0;
   logic             os_tick, bit_tick, inc_pending, running;

   int checks   = 0;
   int failures = 0;

   baud_gen_frac #(
      .ACC_W      (ACC_W),
      .OVERSAMPLE (OS),
      .DEFAULT_INC(2473901)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .en         (en),
      .restart    (restart),
      .inc_wr     (inc_wr),
      .inc_data   (inc_data),
      .os_tick    (os_tick),
      .bit_tick   (bit_tick),
      .inc_pending(inc_pending),
      .running    (running)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input logic [63:0] act,
                          input logic [63:0] lo, input logic [63:0] hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference model: phase as a plain integer, ticks-within-bit as a counter.
   longint      m_phase, m_inc, m_pend;
   bit          m_pending, m_run, exp_os, exp_bit;
   int unsigned m_sub;

   task automatic m_reset();
      m_phase = 0; m_inc = DEF; m_pend = DEF; m_pending = 0; m_run = 0;
      m_sub = 0; exp_os = 0; exp_bit = 0;
   endtask

   task automatic m_step();
      bit was_run;
      bit bnd;
      was_run = m_run;
      bnd     = 0;
      exp_os  = 0;
      exp_bit = 0;
      if (!m_run) begin
         m_phase = 0; m_sub = 0;
         if (en) begin m_run = 1; bnd = 1; end
      end else if (!en) begin
         m_run = 0; m_phase = 0; m_sub = 0;
      end else if (restart) begin
         m_phase = 0; m_sub = OS / 2; bnd = 1;
      end else begin
         m_phase = m_phase + m_inc;
         if (m_phase >= MOD) begin
            m_phase = m_phase - MOD;
            exp_os  = 1;
            m_sub++;
            if (m_sub == OS) begin m_sub = 0; exp_bit = 1; bnd = 1; end
         end
      end
      if (bnd) begin
         if (inc_wr) begin m_inc = longint'(inc_data); m_pend = longint'(inc_data); end
         else if (m_pending) m_inc = m_pend;
         m_pending = 0;
      end else if (inc_wr) begin
         m_pend = longint'(inc_data);
         if (was_run) m_pending = 1;
         else begin m_inc = longint'(inc_data); m_pending = 0; end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge sys_clk or negedge sys_rst_n);
         if (!sys_rst_n) m_reset();
         else m_step();
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial forever begin
      @(negedge sys_clk);
      chk("cyc_os_tick", 64'(os_tick), 64'(exp_os));
      chk("cyc_bit_tick", 64'(bit_tick), 64'(exp_bit));
      chk("cyc_inc_pending", 64'(inc_pending), 64'(m_pending));
      chk("cyc_running", 64'(running), 64'(m_run));
   end

   int first, cnt_os, cnt_bit, bt, drops, pend_seen;
   bit found;

   initial begin
      // Reset state
      repeat (3) @(negedge sys_clk);
      chk("rst_os_tick", 64'(os_tick), 64'd0);
      chk("rst_bit_tick", 64'(bit_tick), 64'd0);
      chk("rst_running", 64'(running), 64'd0);
      chk("rst_inc_active", 64'(dut.inc_active_q), 64'd2473901);
      sys_rst_n = 1'b1;

      // IDLE write of 2^26, then enable
      @(negedge sys_clk); inc_wr = 1'b1; inc_data = ACC_W'(1) << 26;
      @(negedge sys_clk); inc_wr = 1'b0; en = 1'b1;
      first = -1;
      for (int j = 0; j < 8; j++) begin
         @(negedge sys_clk);
         if (os_tick && first < 0) first = j;
      end
      chk("first_os_after_enable", 64'(first), 64'd4);
      cnt_os = 0; cnt_bit = 0;
      for (int j = 0; j < 256; j++) begin
         @(negedge sys_clk);
         cnt_os  += int'(os_tick);
         cnt_bit += int'(bit_tick);
      end
      chk("os_count_256", 64'(cnt_os), 64'd64);
      chk("bit_count_256", 64'(cnt_bit), 64'd4);

      // Restart lands on an edge that would carry; it must be suppressed
      restart = 1'b1;
      @(negedge sys_clk); restart = 1'b0;
      chk("restart_no_tick", 64'(os_tick), 64'd0);
      bt = -1; cnt_os = 0;
      for (int j = 1; j <= 40 && bt < 0; j++) begin
         @(negedge sys_clk);
         cnt_os += int'(os_tick);
         if (bit_tick) bt = j;
      end
      chk("restart_bit_delay", 64'(bt), 64'd32);
      chk("restart_os_before_bit", 64'(cnt_os), 64'd8);

      // Write coinciding with a bit boundary is applied at once
      restart = 1'b1;
      @(negedge sys_clk); restart = 1'b0;
      pend_seen = 0;
      for (int j = 0; j < 31; j++) begin
         @(negedge sys_clk);
         pend_seen += int'(inc_pending);
      end
      inc_wr = 1'b1; inc_data = ACC_W'(1) << 25;
      @(negedge sys_clk); inc_wr = 1'b0;
      chk("sync_write_boundary_bit", 64'(bit_tick), 64'd1);
      pend_seen += int'(inc_pending);
      first = -1;
      for (int j = 1; j <= 12 && first < 0; j++) begin
         @(negedge sys_clk);
         pend_seen += int'(inc_pending);
         if (os_tick) first = j;
      end
      chk("sync_write_spacing", 64'(first), 64'd8);
      chk("sync_write_no_pending", 64'(pend_seen), 64'd0);

      // Mid-bit write waits for the next bit tick
      inc_wr = 1'b1; inc_data = ACC_W'(1) << 26;
      @(negedge sys_clk); inc_wr = 1'b0;
      chk("midbit_pending_set", 64'(inc_pending), 64'd1);
      found = 0; drops = 0;
      for (int j = 0; j < 200 && !found; j++) begin
         @(negedge sys_clk);
         if (bit_tick) found = 1;
         else if (!inc_pending) drops++;
      end
      chk("midbit_bit_seen", 64'(found), 64'd1);
      chk("midbit_pending_held", 64'(drops), 64'd0);
      chk("midbit_pending_cleared", 64'(inc_pending), 64'd0);
      first = -1;
      for (int j = 1; j <= 12 && first < 0; j++) begin
         @(negedge sys_clk);
         if (os_tick) first = j;
      end
      chk("midbit_new_spacing", 64'(first), 64'd4);

      // Drop enable with a write pending, then re-enter RUN
      inc_wr = 1'b1; inc_data = ACC_W'(1) << 25;
      @(negedge sys_clk); inc_wr = 1'b0; en = 1'b0;
      chk("drop_pending_before", 64'(inc_pending), 64'd1);
      @(negedge sys_clk);
      chk("drop_running", 64'(running), 64'd0);
      chk("drop_acc_zero", 64'(dut.u_nco.acc_q), 64'd0);
      chk("drop_os_cnt_zero", 64'(dut.os_cnt_q), 64'd0);
      chk("drop_pending_kept", 64'(inc_pending), 64'd1);
      cnt_os = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge sys_clk);
         cnt_os += int'(os_tick);
      end
      chk("idle_no_ticks", 64'(cnt_os), 64'd0);
      en = 1'b1;
      first = -1;
      for (int j = 0; j < 16; j++) begin
         @(negedge sys_clk);
         if (j == 0) chk("reentry_pending_applied", 64'(inc_pending), 64'd0);
         if (os_tick && first < 0) first = j;
      end
      chk("reentry_first_os", 64'(first), 64'd8);

      // Asynchronous reset between edges while os_tick is high
      inc_wr = 1'b1; inc_data = ACC_W'(1) << 26;
      @(negedge sys_clk); inc_wr = 1'b0;
      found = 0;
      for (int j = 0; j < 40 && !found; j++) begin
         @(negedge sys_clk);
         if (os_tick) found = 1;
      end
      chk("areset_os_seen", 64'(found), 64'd1);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("areset_os_tick", 64'(os_tick), 64'd0);
      chk("areset_bit_tick", 64'(bit_tick), 64'd0);
      chk("areset_running", 64'(running), 64'd0);
      chk("areset_pending", 64'(inc_pending), 64'd0);
      chk("areset_inc_active", 64'(dut.inc_active_q), 64'd2473901);
      en = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk); sys_rst_n = 1'b1;

      // Default increment rate over 40000 cycles
      @(negedge sys_clk); en = 1'b1;
      cnt_os = 0; cnt_bit = 0;
      for (int j = 0; j < 40000; j++) begin
         @(negedge sys_clk);
         cnt_os  += int'(os_tick);
         cnt_bit += int'(bit_tick);
      end
      chk_rng("default_os_count", 64'(cnt_os), 64'd367, 64'd369);
      chk_rng("default_bit_count", 64'(cnt_bit), 64'd22, 64'd24);

      // Randomized traffic, checked by the compare process every cycle
      for (int c = 0; c < 8000; c++) begin
         @(negedge sys_clk);
         if ($urandom_range(0, 199) == 0) en = ~en;
         restart = ($urandom_range(0, 99) == 0);
         inc_wr  = ($urandom_range(0, 39) == 0);
         if (inc_wr) begin
            case ($urandom_range(0, 3))
               0:       inc_data = '0;
               1:       inc_data = ACC_W'(32'h0800_0000 | ($urandom & 32'h07ff_ffff));
               2:       inc_data = ACC_W'($urandom_range(32'h0040_0000, 32'h0200_0000));
               default: inc_data = ACC_W'($urandom);
            endcase
         end
      end
      restart = 1'b0; inc_wr = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
